matrix_iter_ctrl: RTL and testbench

- Iteration sequencer placed directly upstream of the 4-state coefficient-matrix stage. It is also the consumer of that stage's outputs.
- Loads the nine 5-bit coefficients and the 32-bit seed state into the matrix stage.
- Issues one-cycle `start` strobes and feeds the returned state (xpn/xsn/xln/xtin) back as the next xp/xs/xl/xti.
- Discards a warm-up run, then packs four successive 8-bit `xn` outputs into 32-bit words on a valid/ready output stream.

---
 rtl/matrix_iter_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_matrix_iter_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_iter_ctrl.sv
// Iteration sequencer for the 4-state coefficient-matrix stage: seeds it, strobes
// iterations, feeds the state back and packs four xn bytes per 32-bit output word.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | set strobe, coefficients presented to the matrix stage
// ISSUE | start strobe, timeout timer armed
// WAIT  | waiting for done; warm-up discard or byte packing
// PUSH  | word_valid held until word_ready
// FIN   | one-cycle finished pulse
module matrix_iter_ctrl #(
  parameter int WARMUP  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_words,
  input  logic [31:0]      seed_p,
  input  logic [31:0]      seed_s,
  input  logic [31:0]      seed_l,
  input  logic [31:0]      seed_ti,
  input  logic [4:0]       e12_cfg,
  input  logic [4:0]       e13_cfg,
  input  logic [4:0]       e14_cfg,
  input  logic [4:0]       e21_cfg,
  input  logic [4:0]       e23_cfg,
  input  logic [4:0]       e24_cfg,
  input  logic [4:0]       e31_cfg,
  input  logic [4:0]       e32_cfg,
  input  logic [4:0]       e34_cfg,
  output logic [4:0]       e12_in,
  output logic [4:0]       e13_in,
  output logic [4:0]       e14_in,
  output logic [4:0]       e21_in,
  output logic [4:0]       e23_in,
  output logic [4:0]       e24_in,
  output logic [4:0]       e31_in,
  output logic [4:0]       e32_in,
  output logic [4:0]       e34_in,
  output logic             set,
  output logic             start,
  output logic [31:0]      xp,
  output logic [31:0]      xs,
  output logic [31:0]      xl,
  output logic [31:0]      xti,
  input  logic [7:0]       xn,
  input  logic             done,
  input  logic [31:0]      xpn,
  input  logic [31:0]      xsn,
  input  logic [31:0]      xln,
  input  logic [31:0]      xtin,
  output logic [31:0]      word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             finished,
  output logic             err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WU_W-1:0] WU_MAX  = WU_W'(WARMUP);
  localparam logic [TM_W-1:0] TM_LOAD = TM_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] nw_q;
  logic [CNT_W-1:0] wdone;
  logic [CNT_W-1:0] wdone_inc;
  logic [WU_W-1:0]  wcnt;
  logic [1:0]       bcnt;
  logic [TM_W-1:0]  tmr;

  assign wdone_inc  = wdone + 1'b1;
  assign set        = (state == LOAD);
  assign start      = (state == ISSUE);
  assign word_valid = (state == PUSH);
  assign finished   = (state == FIN);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      nw_q      <= '0;
      wdone     <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      tmr       <= '0;
      err       <= 1'b0;
      word_data <= '0;
      xp        <= '0;
      xs        <= '0;
      xl        <= '0;
      xti       <= '0;
      e12_in    <= '0;
      e13_in    <= '0;
      e14_in    <= '0;
      e21_in    <= '0;
      e23_in    <= '0;
      e24_in    <= '0;
      e31_in    <= '0;
      e32_in    <= '0;
      e34_in    <= '0;
    end else if (abort) begin
      // abort only moves the FSM; datapath registers keep their contents
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            xp     <= seed_p;
            xs     <= seed_s;
            xl     <= seed_l;
            xti    <= seed_ti;
            e12_in <= e12_cfg;
            e13_in <= e13_cfg;
            e14_in <= e14_cfg;
            e21_in <= e21_cfg;
            e23_in <= e23_cfg;
            e24_in <= e24_cfg;
            e31_in <= e31_cfg;
            e32_in <= e32_cfg;
            e34_in <= e34_cfg;
            nw_q   <= num_words;
            err    <= 1'b0;
            wdone  <= '0;
            wcnt   <= '0;
            bcnt   <= '0;
            state  <= (num_words == '0) ? FIN : LOAD;
          end
        end
        LOAD:  state <= ISSUE;
        ISSUE: begin
          tmr   <= TM_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            xp  <= xpn;
            xs  <= xsn;
            xl  <= xln;
            xti <= xtin;
            if (wcnt < WU_MAX) begin
              wcnt  <= wcnt + 1'b1;
              state <= ISSUE;
            end else begin
              word_data[{bcnt, 3'b000} +: 8] <= xn;
              bcnt  <= bcnt + 1'b1;
              state <= (bcnt == 2'd3) ? PUSH : ISSUE;
            end
          end else if (tmr == '0) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PUSH: begin
          if (word_ready) begin
            bcnt  <= '0;
            wdone <= wdone_inc;
            state <= (wdone_inc == nw_q) ? FIN : ISSUE;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_iter_ctrl.sv
// Scoreboard bench for matrix_iter_ctrl with a feedback stub standing in for the
// matrix stage: xn = xp[7:0]^xti[7:0], xpn = xp+1, other state passes through.
module tb_matrix_iter_ctrl;
  localparam int WARMUP  = 2;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 16;

  logic clk, rst_n, go, abort, set, start, done, word_valid, word_ready, busy, finished, err;
  logic [CNT_W-1:0] num_words;
  logic [31:0] seed_p, seed_s, seed_l, seed_ti, xp, xs, xl, xti, xpn, xsn, xln, xtin, word_data;
  logic [4:0] e12_cfg, e13_cfg, e14_cfg, e21_cfg, e23_cfg, e24_cfg, e31_cfg, e32_cfg, e34_cfg;
  logic [4:0] e12_in, e13_in, e14_in, e21_in, e23_in, e24_in, e31_in, e32_in, e34_in;
  logic [7:0] xn;

  logic        done_q, stray, mute;
  logic [31:0] xp_at_start;
  logic [44:0] exp_coef;
  logic [31:0] sb[$];
  int checks, errors, n_set, n_start, n_fin;

  matrix_iter_ctrl #(.WARMUP(WARMUP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .num_words(num_words),
    .seed_p(seed_p), .seed_s(seed_s), .seed_l(seed_l), .seed_ti(seed_ti),
    .e12_cfg(e12_cfg), .e13_cfg(e13_cfg), .e14_cfg(e14_cfg), .e21_cfg(e21_cfg),
    .e23_cfg(e23_cfg), .e24_cfg(e24_cfg), .e31_cfg(e31_cfg), .e32_cfg(e32_cfg),
    .e34_cfg(e34_cfg),
    .e12_in(e12_in), .e13_in(e13_in), .e14_in(e14_in), .e21_in(e21_in),
    .e23_in(e23_in), .e24_in(e24_in), .e31_in(e31_in), .e32_in(e32_in),
    .e34_in(e34_in),
    .set(set), .start(start), .xp(xp), .xs(xs), .xl(xl), .xti(xti),
    .xn(xn), .done(done), .xpn(xpn), .xsn(xsn), .xln(xln), .xtin(xtin),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .finished(finished), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // matrix stage stub: registered done one cycle after start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0; xn <= '0; xpn <= '0; xsn <= '0; xln <= '0; xtin <= '0;
      xp_at_start <= '0;
    end else begin
      done_q <= start & ~mute;
      if (start) begin
        xn          <= xp[7:0] ^ xti[7:0];
        xpn         <= xp + 32'd1;
        xsn         <= xs;
        xln         <= xl;
        xtin        <= xti;
        xp_at_start <= xp;
      end
    end
  end
  assign done = done_q | stray;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // monitor: sampled 1 time unit after the falling edge
  initial begin
    logic        pv, pr;
    logic [31:0] pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", word_valid, 1);
        check("hold_data", word_data, pd);
      end
      if (word_valid) check("no_start_in_push", start, 0);
      if (done_q) check("xp_hold", xp, xp_at_start);
      if (set) begin
        n_set++;
        check("set_coef", {e12_in, e13_in, e14_in, e21_in, e23_in, e24_in, e31_in, e32_in, e34_in},
              exp_coef);
      end
      if (start) n_start++;
      if (finished) n_fin++;
      if (word_valid && word_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected: got %0h expected none", word_data);
        end else begin
          check("word", word_data, sb.pop_front());
        end
      end
      pv = word_valid; pr = word_ready; pd = word_data;
    end
  end

  task automatic launch(input logic [CNT_W-1:0] nw, input logic [31:0] sp, input logic [31:0] sti,
                        input logic [44:0] cfg);
    num_words = nw;
    seed_p    = sp;
    seed_s    = 32'hA5A5_0001;
    seed_l    = 32'h5A5A_0002;
    seed_ti   = sti;
    {e12_cfg, e13_cfg, e14_cfg, e21_cfg, e23_cfg, e24_cfg, e31_cfg, e32_cfg, e34_cfg} = cfg;
    exp_coef = cfg;
    n_set = 0; n_start = 0; n_fin = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int k = 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    check(nm, busy, 0);
  endtask

  task automatic wait_start(input string nm);
    int k = 0;
    while (!start && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(nm, start, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!word_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [44:0] cfg_a, cfg_b;
  initial begin
    int n;
    cfg_a = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    cfg_b = {5'd31, 5'd17, 5'd0, 5'd12, 5'd30, 5'd1, 5'd22, 5'd5, 5'd16};
    checks = 0; errors = 0; n_set = 0; n_start = 0; n_fin = 0;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; word_ready = 1'b1; stray = 1'b0; mute = 1'b0;
    exp_coef = '0;
    num_words = '0; seed_p = '0; seed_s = '0; seed_l = '0; seed_ti = '0;
    {e12_cfg, e13_cfg, e14_cfg, e21_cfg, e23_cfg, e24_cfg, e31_cfg, e32_cfg, e34_cfg} = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {set, start, word_valid, busy, finished, err}, 0);
    check("rst_data", {word_data, xp, xs, xl, xti}, 0);
    check("rst_coef", {e12_in, e13_in, e14_in, e21_in, e23_in, e24_in, e31_in, e32_in, e34_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // stray done in IDLE must not move anything
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("stray_idle_busy", busy, 0);

    // run A: three words, first word latency, go ignored while busy
    sb.push_back(32'h0504_0302);
    sb.push_back(32'h0908_0706);
    sb.push_back(32'h0D0C_0B0A);
    launch(3, 32'h0, 32'h0, cfg_a);
    wait_valid(n);
    check("first_valid_lat", n, 2 + 2 * WARMUP + 8);
    go = 1'b1; num_words = 5;
    @(negedge clk);
    go = 1'b0; num_words = 3;
    wait_idle(100, "runA_idle");
    check("runA_sets", n_set, 1);
    check("runA_starts", n_start, WARMUP + 12);
    check("runA_fin", n_fin, 1);
    check("runA_state", {xp, xs, xl, xti}, {32'h0000_000E, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0});
    check("runA_sb_empty", sb.size(), 0);

    // run B: backpressure on the first word with a stray done during PUSH
    sb.push_back(32'hFEFF_0001);
    sb.push_back(32'hFAFB_FCFD);
    word_ready = 1'b0;
    launch(2, 32'h0000_00FC, 32'h0000_00FF, cfg_b);
    wait_valid(n);
    check("runB_valid", word_valid, 1);
    for (int i = 0; i < 20; i++) begin
      stray = (i == 5);
      @(negedge clk);
    end
    stray = 1'b0;
    check("runB_still_valid", word_valid, 1);
    check("runB_starts_held", n_start, WARMUP + 4);
    word_ready = 1'b1;
    wait_idle(100, "runB_idle");
    check("runB_starts", n_start, WARMUP + 8);
    check("runB_fin", n_fin, 1);
    check("runB_xp", xp, 32'h0000_0106);

    // run C: done never returns
    mute = 1'b1;
    launch(1, 32'h0, 32'h0, cfg_a);
    wait_start("runC_start");
    n = 0;
    while (!err && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("timeout_lat", n, TIMEOUT + 1);
    check("timeout_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("timeout_sticky", err, 1);
    check("timeout_no_fin", n_fin, 0);
    mute = 1'b0;

    // run D: next go clears err
    sb.push_back(32'h0504_0302);
    launch(1, 32'h0, 32'h0, cfg_b);
    check("err_cleared", err, 0);
    wait_idle(100, "runD_idle");
    check("runD_fin", n_fin, 1);

    // run E: zero words, then go during FIN is ignored
    launch(0, 32'h0, 32'h0, cfg_a);
    check("zero_fin", finished, 1);
    go = 1'b1; num_words = 1;
    @(negedge clk);
    go = 1'b0;
    check("go_in_fin_ignored", busy, 0);
    check("zero_no_set_start", {n_set[15:0], n_start[15:0]}, 0);
    check("zero_fin_cnt", n_fin, 1);

    // go together with abort in IDLE
    n_set = 0;
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    check("go_abort_idle", busy, 0);
    @(negedge clk);
    check("go_abort_no_set", n_set, 0);

    // run G: abort in WAIT
    launch(1, 32'h0000_0040, 32'h0, cfg_a);
    wait_start("runG_start");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ctrl", {busy, start, word_valid, set}, 0);
    check("abort_xp_kept", xp, 32'h0000_0040);
    repeat (3) @(negedge clk);
    check("abort_no_fin", n_fin, 0);

    // run H: reset during PUSH
    word_ready = 1'b0;
    launch(1, 32'h0, 32'h0, cfg_b);
    wait_valid(n);
    check("runH_valid", word_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {set, start, word_valid, busy, finished, err}, 0);
    check("rst_mid_data", {word_data, xp, xti, 3'b000, e12_in, e34_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);

    // recovery run after reset
    sb.push_back(32'h0504_0302);
    launch(1, 32'h0, 32'h0, cfg_a);
    wait_idle(100, "runI_idle");
    check("runI_fin", n_fin, 1);
    check("sb_final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
